n2_com_dp_32x72_fifo_ctl: RTL and testbench
===========================================

# n2_com_dp_32x72_fifo_ctl

Single-clock FIFO controller that sits directly in front of the 32x72 datapath register-file array and turns it into a 32-entry, 72-bit-wide valid/ready FIFO. It accepts pushes from the producing unit, generates the array write and read strobes and addresses, and absorbs the array's one-cycle read latency with a two-entry output buffer. Total capacity is 34 words: 32 in the array plus 2 in the output buffer. The consumer sees full pop throughput with no bubbles.

## Interface
- AFULL_THR, default 28: `ary_afull` asserts when array occupancy is greater than or equal to this value. Legal range 1..32.
- l2clk  in  1  block clock; also drives the array `rdclk`/`wrclk`
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all contents; same effect as `rst` on state
- push_vld  in  1  producer has a word
- push_rdy  out  1  controller can accept a word
- push_data  in  72  write data
- pop_vld  out  1  `pop_data` is valid
- pop_rdy  in  1  consumer takes the word
- pop_data  out  72  head word
- ary_wr_en  out  1  array `wr_en`
- ary_wr_adr  out  5  array `wr_adr`
- ary_din  out  72  array `din`; equals `push_data`
- ary_rd_en  out  1  array `rd_en`
- ary_rd_adr  out  5  array `rd_adr`
- ary_dout  in  72  array `dout`; valid the cycle after `ary_rd_en`
- ary_cnt  out  6  array occupancy, 0..32
- ary_afull  out  1  `ary_cnt >= AFULL_THR`
- ary_empty  out  1  `ary_cnt == 0`

## Operation
State:
- `wptr[5:0]` and `rptr[5:0]`: 5-bit address plus wrap bit.
- `ary_cnt = wptr - rptr`, computed mod 64.
- `rd_inflt`: 1 bit.
- `obuf[0:1]` with occupancy `ocnt` (0..2).

Push and write:
- A push fires when `push_vld & push_rdy`.
- `push_rdy = (ary_cnt != 32) & ~rst & ~flush`. A read in the same cycle does not free space early.
- On a push, drive `ary_wr_en=1` and `ary_wr_adr=wptr[4:0]` combinationally in the same cycle. `wptr` increments at the clock edge.

Array read:
- Issue a read when `ary_cnt != 0` and `(ocnt + rd_inflt - pop) < 2`, where `pop = pop_vld & pop_rdy`.
- On a read, drive `ary_rd_en=1` and `ary_rd_adr=rptr[4:0]`. `rptr` increments at the edge, and `rd_inflt` is set to 1 for the next cycle.
- A word written in cycle N becomes readable from cycle N+1. There is no same-cycle write-to-read bypass.

Output buffer:
- While `rd_inflt=1`, `ary_dout` is captured at the end of the cycle into `obuf[ocnt - pop]`.
- `obuf` shifts on a pop.
- `pop_vld = (ocnt != 0)` and `pop_data = obuf[0]`. Both come straight from registers, never combinationally from `ary_dout`.

Simultaneous events:
- Push and read in the same cycle are independent. `ary_cnt` is unchanged.
- Pop, capture and issue can all occur in the same cycle. `ocnt` never exceeds 2.

Boundary conditions:
- Wrap-around: the address wraps from 31 to 0 and the wrap bit toggles.
- Full: `ary_cnt == 32` exactly when `wptr[4:0] == rptr[4:0]` and the wrap bits differ.
- Overflow and underflow are impossible by construction. Any attempt to push or read past the limits is a design assertion failure.

Reset and flush (`rst` or `flush`):
- Pointers, `ary_cnt`, `rd_inflt` and `ocnt` go to 0.
- An in-flight read's data is discarded.
- While `rst` or `flush` is high, `ary_wr_en` and `ary_rd_en` are 0.
- Array contents are not cleared.

Output values during reset: `push_rdy=0`, `pop_vld=0`, `pop_data=0`, `ary_wr_en=0`, `ary_rd_en=0`, `ary_cnt=0`, `ary_afull=0`, `ary_empty=1`.

## Timing
- Push-to-pop latency, empty FIFO: push in cycle N, read issued in N+1, capture at the end of N+2, `pop_vld=1` in N+3.
- Sustained throughput is one push and one pop per cycle.
- `push_rdy`, `ary_cnt`, `ary_afull` and `ary_empty` are registered-state functions. `push_rdy` has no combinational path from `pop_rdy`.
- Array read data is used exactly one cycle after `ary_rd_en`.

## Structure
- Shared package `n2_com_fifo_pkg` holds `FIFO_DEPTH=32`, `FIFO_AW=5`, `FIFO_DW=72` and a `ptr_t` typedef (6-bit pointer).
- One natural sub-module: `n2_com_fifo_obuf2`, the two-entry output buffer with capture, shift and pop logic.
- The controller and the array are instantiated side by side in the parent.

## Test plan
- Reset, then push 1 word (0xA5) in cycle 0 -> `ary_wr_adr=0`; `ary_rd_en` in cycle 1; `pop_vld=1` with `pop_data=0xA5` in cycle 3.
- Push 34 words with `pop_rdy=0` -> `ary_cnt` reaches 32 after 34 accepted pushes (2 in `obuf`); `push_rdy=0`; `ary_afull=1` once `ary_cnt` reaches 28.
- Continuous push and pop for 100 words with `pop_rdy=1` -> in-order data; no bubbles after the first `pop_vld`; address wraps 31 to 0 at least 3 times.
- Random `pop_rdy` at 50% with streaming pushes -> scoreboard matches; `ocnt <= 2` always; no read is issued when `ary_cnt == 0`.
- Full FIFO, then pop once -> `push_rdy` rises only after `ary_cnt` drops below 32, never in the same cycle as the triggering read.
- Assert `flush` while a read is in flight with 10 words queued -> the next cycle shows `pop_vld=0`, `ary_cnt=0`, `ary_empty=1`; a new push then pops its own data, not stale data.

Source files
------------

// File: rtl/n2_com_fifo_pkg.sv
// Shared constants and types for the 32x72 datapath FIFO controller.
//   FIFO_DEPTH : array entries
//   FIFO_AW    : array address width
//   FIFO_DW    : data width
//   ptr_t      : array address plus wrap bit
package n2_com_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 32;
  localparam int unsigned FIFO_AW    = 5;
  localparam int unsigned FIFO_DW    = 72;

  typedef logic [FIFO_AW:0] ptr_t;

endpackage

// File: rtl/n2_com_fifo_obuf2.sv
// Two-entry output buffer that absorbs the array's one-cycle read latency.
//   clk      : clock
//   clr      : synchronous clear of occupancy and contents
//   cap      : capture din at the end of this cycle
//   din      : array read data
//   pop_rdy  : consumer takes the head word
//   vld      : head word valid
//   data     : head word
//   cnt      : occupancy (0..2)
//   pop_c    : pop fires this cycle (combinational)
module n2_com_fifo_obuf2
  import n2_com_fifo_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               cap,
  input  logic [FIFO_DW-1:0] din,
  input  logic               pop_rdy,
  output logic               vld,
  output logic [FIFO_DW-1:0] data,
  output logic [1:0]         cnt,
  output logic               pop_c
);

  logic [FIFO_DW-1:0] obuf0;
  logic [FIFO_DW-1:0] obuf1;
  logic [1:0]         ocnt;
  logic [1:0]         cnt_after_pop;

  assign pop_c         = (ocnt != 2'd0) & pop_rdy;
  assign cnt_after_pop = ocnt - 2'(pop_c);

  assign vld  = (ocnt != 2'd0);
  assign data = obuf0;
  assign cnt  = ocnt;

  // Shift on pop first; a capture into slot 0 overrides the shifted value.
  always_ff @(posedge clk) begin
    if (clr) begin
      ocnt  <= 2'd0;
      obuf0 <= '0;
      obuf1 <= '0;
    end else begin
      if (pop_c) begin
        obuf0 <= obuf1;
      end
      if (cap) begin
        if (cnt_after_pop == 2'd0) begin
          obuf0 <= din;
        end else begin
          obuf1 <= din;
        end
      end
      ocnt <= cnt_after_pop + 2'(cap);
      assert (!(cap && cnt_after_pop == 2'd2))
        else $error("obuf2 capture with no free slot");
    end
  end

endmodule

// File: rtl/n2_com_dp_32x72_fifo_ctl.sv
// Controller that turns the 32x72 register-file array into a 34-word
// valid/ready FIFO (32 array entries plus a 2-entry output buffer).
//   l2clk      : clock (also the array read/write clock)
//   rst        : synchronous active-high reset
//   flush      : synchronous clear of all contents
//   push_*     : producer side valid/ready/data
//   pop_*      : consumer side valid/ready/data
//   ary_wr_*   : array write strobe, address and data
//   ary_rd_*   : array read strobe and address; ary_dout arrives next cycle
//   ary_cnt    : array occupancy, ary_afull / ary_empty flags
module n2_com_dp_32x72_fifo_ctl
  import n2_com_fifo_pkg::*;
#(
  parameter int unsigned AFULL_THR = 28
) (
  input  logic               l2clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push_vld,
  output logic               push_rdy,
  input  logic [FIFO_DW-1:0] push_data,
  output logic               pop_vld,
  input  logic               pop_rdy,
  output logic [FIFO_DW-1:0] pop_data,
  output logic               ary_wr_en,
  output logic [FIFO_AW-1:0] ary_wr_adr,
  output logic [FIFO_DW-1:0] ary_din,
  output logic               ary_rd_en,
  output logic [FIFO_AW-1:0] ary_rd_adr,
  input  logic [FIFO_DW-1:0] ary_dout,
  output logic [FIFO_AW:0]   ary_cnt,
  output logic               ary_afull,
  output logic               ary_empty
);

  ptr_t       wptr;
  ptr_t       rptr;
  logic       rd_inflt;
  logic       clr;
  logic [1:0] ocnt;
  logic       pop;
  logic [2:0] occ_next;

  assign clr = rst | flush;

  // Occupancy is a pure function of the registered pointers.
  assign ary_cnt   = wptr - rptr;
  assign ary_afull = (ary_cnt >= (FIFO_AW + 1)'(AFULL_THR));
  assign ary_empty = (ary_cnt == '0);

  assign push_rdy   = (ary_cnt != (FIFO_AW + 1)'(FIFO_DEPTH)) & ~clr;
  assign ary_wr_en  = push_vld & push_rdy;
  assign ary_wr_adr = wptr[FIFO_AW-1:0];
  assign ary_din    = push_data;

  // Only issue a read if its data will have a buffer slot when it returns.
  assign occ_next   = 3'(ocnt) + 3'(rd_inflt) - 3'(pop);
  assign ary_rd_en  = (ary_cnt != '0) & (occ_next < 3'd2) & ~clr;
  assign ary_rd_adr = rptr[FIFO_AW-1:0];

  // Pointer and in-flight tracking.
  always_ff @(posedge l2clk) begin
    if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_inflt <= 1'b0;
    end else begin
      if (ary_wr_en) begin
        wptr <= wptr + ptr_t'(1);
      end
      if (ary_rd_en) begin
        rptr <= rptr + ptr_t'(1);
      end
      rd_inflt <= ary_rd_en;
      assert (!(ary_wr_en && ary_cnt == (FIFO_AW + 1)'(FIFO_DEPTH)))
        else $error("push into full array");
      assert (!(ary_rd_en && ary_cnt == '0))
        else $error("read from empty array");
    end
  end

  // In-flight data is dropped on clear by gating the capture.
  n2_com_fifo_obuf2 u_obuf (
    .clk     (l2clk),
    .clr     (clr),
    .cap     (rd_inflt & ~clr),
    .din     (ary_dout),
    .pop_rdy (pop_rdy),
    .vld     (pop_vld),
    .data    (pop_data),
    .cnt     (ocnt),
    .pop_c   (pop)
  );

endmodule

// File: tb/tb_n2_com_dp_32x72_fifo_ctl.sv
module tb_n2_com_dp_32x72_fifo_ctl;

  logic        clk = 1'b0;
  logic        rst, flush, push_vld, push_rdy, pop_vld, pop_rdy;
  logic [71:0] push_data, pop_data, ary_din, ary_dout;
  logic        ary_wr_en, ary_rd_en, ary_afull, ary_empty;
  logic [4:0]  ary_wr_adr, ary_rd_adr;
  logic [5:0]  ary_cnt;

  int checks = 0;
  int errors = 0;

  logic [71:0] q[$];
  logic [71:0] mem [32];

  always #5 clk = ~clk;

  n2_com_dp_32x72_fifo_ctl #(.AFULL_THR(28)) dut (
    .l2clk(clk), .rst(rst), .flush(flush),
    .push_vld(push_vld), .push_rdy(push_rdy), .push_data(push_data),
    .pop_vld(pop_vld), .pop_rdy(pop_rdy), .pop_data(pop_data),
    .ary_wr_en(ary_wr_en), .ary_wr_adr(ary_wr_adr), .ary_din(ary_din),
    .ary_rd_en(ary_rd_en), .ary_rd_adr(ary_rd_adr), .ary_dout(ary_dout),
    .ary_cnt(ary_cnt), .ary_afull(ary_afull), .ary_empty(ary_empty)
  );

  // Array model: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (ary_wr_en) mem[ary_wr_adr] <= ary_din;
    if (ary_rd_en) ary_dout <= mem[ary_rd_adr];
    else           ary_dout <= 72'({$urandom(), $urandom(), $urandom()});
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge: rule checks and scoreboard.
  task automatic sample();
    int sz;
    @(negedge clk);
    sz = q.size();
    chk("afull_rule", ary_afull, 72'(ary_cnt >= 6'd28));
    chk("empty_rule", ary_empty, 72'(ary_cnt == 6'd0));
    chk("push_rdy_rule", push_rdy, 72'((ary_cnt != 6'd32) && !rst && !flush));
    chk("cnt_range", 72'(ary_cnt <= 6'd32), 72'd1);
    if (!rst && !flush) begin
      chk("outside_array", 72'((sz >= int'(ary_cnt)) && (sz - int'(ary_cnt) <= 2)), 72'd1);
    end
    if (ary_rd_en) chk("rd_not_empty", 72'(ary_cnt != 6'd0), 72'd1);
    if (ary_wr_en) chk("din_eq_push", ary_din, push_data);
    if (pop_vld) begin
      chk("pop_has_word", 72'(sz > 0), 72'd1);
      if (sz > 0) chk("pop_data", pop_data, q[0]);
    end
    if (rst || flush) begin
      q.delete();
    end else begin
      if (pop_vld && pop_rdy && sz > 0) void'(q.pop_front());
      if (push_vld && push_rdy) q.push_back(push_data);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  function automatic logic [71:0] rnd72();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    int n, cyc, wraps, first_seen, popped;
    logic [4:0] prev_adr;

    rst = 1'b1; flush = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0; push_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset outputs
    push_vld = 1'b1;
    sample();
    chk("rst_push_rdy", push_rdy, 0);
    chk("rst_pop_vld", pop_vld, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_wr_en", ary_wr_en, 0);
    chk("rst_rd_en", ary_rd_en, 0);
    chk("rst_cnt", ary_cnt, 0);
    chk("rst_afull", ary_afull, 0);
    chk("rst_empty", ary_empty, 1);
    adv();
    rst = 1'b0; push_vld = 1'b0;

    // Single-word latency
    push_vld = 1'b1; push_data = 72'hA5;
    sample();
    chk("lat_wr_en", ary_wr_en, 1);
    chk("lat_wr_adr", ary_wr_adr, 0);
    adv();
    push_vld = 1'b0;
    sample();
    chk("lat_rd_en", ary_rd_en, 1);
    chk("lat_rd_adr", ary_rd_adr, 0);
    chk("lat_c1_pop_vld", pop_vld, 0);
    adv();
    sample();
    chk("lat_c2_pop_vld", pop_vld, 0);
    adv();
    pop_rdy = 1'b1;
    sample();
    chk("lat_c3_pop_vld", pop_vld, 1);
    chk("lat_c3_pop_data", pop_data, 72'hA5);
    adv();
    pop_rdy = 1'b0;
    step();
    chk("lat_drained", pop_vld, 0);

    // Fill with no pops: 34 accepted pushes
    n = 0; cyc = 0;
    while (n < 34 && cyc < 80) begin
      push_vld = 1'b1; push_data = rnd72();
      sample();
      if (push_rdy) n++;
      adv();
      cyc++;
    end
    chk("fill_accepted", 72'(n), 72'd34);
    push_vld = 1'b1; push_data = rnd72();
    repeat (3) step();
    sample();
    chk("full_cnt", ary_cnt, 32);
    chk("full_push_rdy", push_rdy, 0);
    chk("full_afull", ary_afull, 1);
    chk("full_pop_vld", pop_vld, 1);
    adv();

    // Pop once from full: space frees only after the read retires the slot
    pop_rdy = 1'b1;
    sample();
    chk("pop1_rd_en", ary_rd_en, 1);
    chk("pop1_push_rdy", push_rdy, 0);
    adv();
    pop_rdy = 1'b0; push_data = rnd72();
    sample();
    chk("pop1_cnt31", ary_cnt, 31);
    chk("pop1_push_rdy_rise", push_rdy, 1);
    adv();
    push_vld = 1'b0;

    // Drain
    pop_rdy = 1'b1; cyc = 0;
    while ((q.size() != 0 || pop_vld) && cyc < 100) begin step(); cyc++; end
    chk("drain_done", 72'(q.size()), 72'd0);
    pop_rdy = 1'b0;

    // Streaming 100 words, pop always ready
    n = 0; cyc = 0; wraps = 0; first_seen = 0; popped = 0; prev_adr = ary_wr_adr;
    pop_rdy = 1'b1;
    while (popped < 100 && cyc < 300) begin
      push_vld = (n < 100); push_data = rnd72();
      sample();
      if (ary_wr_en) begin
        if (prev_adr == 5'd31 && ary_wr_adr == 5'd0) wraps++;
        prev_adr = ary_wr_adr;
        n++;
      end
      if (first_seen != 0) chk("no_bubble", pop_vld, 1);
      if (pop_vld) begin first_seen = 1; popped++; end
      adv();
      cyc++;
    end
    chk("stream_popped", 72'(popped), 72'd100);
    chk("stream_wraps", 72'(wraps >= 3), 72'd1);
    push_vld = 1'b0;
    repeat (4) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      push_vld = ($urandom_range(3) != 0);
      push_data = rnd72();
      pop_rdy = $urandom_range(1);
      step();
    end
    push_vld = 1'b0; pop_rdy = 1'b1; cyc = 0;
    while ((q.size() != 0 || pop_vld) && cyc < 100) begin step(); cyc++; end
    chk("rand_drain", 72'(q.size()), 72'd0);
    pop_rdy = 1'b0;

    // Flush with a read in flight and 10 words queued
    for (int i = 0; i < 10; i++) begin
      push_vld = 1'b1; push_data = rnd72();
      step();
    end
    push_vld = 1'b0;
    repeat (4) step();
    pop_rdy = 1'b1;
    sample();
    chk("fl_rd_issue", ary_rd_en, 1);
    adv();
    pop_rdy = 1'b0; flush = 1'b1; push_vld = 1'b1; push_data = rnd72();
    sample();
    chk("fl_push_rdy", push_rdy, 0);
    chk("fl_wr_en", ary_wr_en, 0);
    chk("fl_rd_en", ary_rd_en, 0);
    adv();
    flush = 1'b0; push_vld = 1'b0;
    sample();
    chk("fl_pop_vld", pop_vld, 0);
    chk("fl_cnt", ary_cnt, 0);
    chk("fl_empty", ary_empty, 1);
    adv();
    step();
    chk("fl_no_stale", pop_vld, 0);
    push_vld = 1'b1; push_data = 72'h1234;
    step();
    push_vld = 1'b0;
    cyc = 0;
    while (!pop_vld && cyc < 10) begin step(); cyc++; end
    chk("fl_new_vld", pop_vld, 1);
    chk("fl_new_data", pop_data, 72'h1234);
    pop_rdy = 1'b1;
    step();
    pop_rdy = 1'b0;
    step();
    chk("fl_end_empty", pop_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
